// File: rtl/pc_ras_unit.sv
// pc_ras_unit -- program counter with next-PC selection and an optional
// circular return-address stack (RAS).
//
// Build option: define PC_RAS_UNIT_RAS_EN to include the return-address stack.
// Without it, CALL behaves as JUMP, RET behaves as JREG, and all RAS outputs
// are tied to their empty/idle values.
//
// Parameters:
//   WIDTH     PC/target width (28..64)
//   RESET_PC  PC loaded on reset (truncated or zero-extended to WIDTH)
//   RAS_DEPTH return-address-stack entries (2..16)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   en           update enable for the PC and RAS (0 = stall)
//   pc_src       next-PC mode: 0 SEQ, 1 BEQ, 2 BNE, 3 JUMP, 4 CALL, 5 JREG,
//                6 RET, 7 reserved (treated as SEQ)
//   zero         ALU equality flag used by BEQ/BNE
//   instr_index  26-bit jump index; bits [15:0] double as the branch offset
//   reg_target   GPR value used by JREG/RET
//   pc           current PC (registered)
//   npc          next PC (combinational)
//   pc4          pc + 4
//   ras_top      top RAS entry (0 when the stack is empty)
//   ras_count    number of valid RAS entries
//   ras_empty    ras_count == 0
//   ras_full     ras_count == RAS_DEPTH
//   ras_overflow sticky flag: a CALL arrived while the stack was full
//   ret_mismatch one-cycle pulse after a RET whose target differs from ras_top
module pc_ras_unit #(
  parameter int unsigned  WIDTH     = 32,
  parameter logic [63:0]  RESET_PC  = 64'h0000_3000,
  parameter int unsigned  RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       pc_src,
  input  logic             zero,
  input  logic [25:0]      instr_index,
  input  logic [WIDTH-1:0] reg_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic [WIDTH-1:0] pc4,
  output logic [WIDTH-1:0] ras_top,
  output logic [4:0]       ras_count,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ret_mismatch
);

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BEQ  = 3'd1,
    SRC_BNE  = 3'd2,
    SRC_JUMP = 3'd3,
    SRC_CALL = 3'd4,
    SRC_JREG = 3'd5,
    SRC_RET  = 3'd6,
    SRC_RSVD = 3'd7
  } pc_src_e;

  localparam logic [WIDTH-1:0] RESET_PC_W = RESET_PC[WIDTH-1:0];

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 28 || WIDTH > 64) begin : g_bad_width
    $error("pc_ras_unit: WIDTH must be in 28..64");
  end
  if (RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : g_bad_depth
    $error("pc_ras_unit: RAS_DEPTH must be in 2..16");
  end

  pc_src_e          mode;
  logic [WIDTH-1:0] branch_offset;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;

  assign mode = pc_src_e'(pc_src);
  assign pc4  = pc + WIDTH'(4);

  // Word offset: sign-extend the 16-bit field and scale by 4; wraps modulo 2^WIDTH.
  assign branch_offset = {{(WIDTH-18){instr_index[15]}}, instr_index[15:0], 2'b00};
  assign branch_target = pc4 + branch_offset;

  // With WIDTH == 28 there are no upper PC bits to keep.
  if (WIDTH > 28) begin : g_jump_upper
    assign jump_target = {pc[WIDTH-1:28], instr_index, 2'b00};
  end else begin : g_jump_flat
    assign jump_target = {instr_index, 2'b00};
  end

  // Next-PC selection. The RAS never overrides the architectural RET target.
  always_comb begin
    npc = pc4;
    case (mode)
      SRC_BEQ:            npc = zero ? branch_target : pc4;
      SRC_BNE:            npc = zero ? pc4 : branch_target;
      SRC_JUMP, SRC_CALL: npc = jump_target;
      SRC_JREG, SRC_RET:  npc = reg_target;
      default:            npc = pc4;
    endcase
  end

  // PC register: reset wins, otherwise advance only when enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC_W;
    end else if (en) begin
      pc <= npc;
    end
  end

`ifdef PC_RAS_UNIT_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_inc;
  logic [PTR_W-1:0] sp_dec;
  logic             do_push;
  logic             do_pop;

  // sp is the next write slot; once full it points at the oldest entry,
  // so a push there overwrites it and keeps the ring consistent.
  assign sp_inc = (sp == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp + PTR_W'(1);
  assign sp_dec = (sp == '0) ? PTR_W'(RAS_DEPTH - 1) : sp - PTR_W'(1);

  assign ras_empty = (ras_count == 5'd0);
  assign ras_full  = (ras_count == 5'(RAS_DEPTH));
  assign ras_top   = ras_empty ? '0 : ras_mem[sp_dec];

  assign do_push = en && (mode == SRC_CALL);
  assign do_pop  = en && (mode == SRC_RET) && !ras_empty;

  // Stack state: reset clears everything and discards any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp           <= '0;
      ras_count    <= 5'd0;
      ras_overflow <= 1'b0;
      ret_mismatch <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      ret_mismatch <= 1'b0;
      if (do_push) begin
        ras_mem[sp] <= pc4;
        sp          <= sp_inc;
        if (ras_full) begin
          ras_overflow <= 1'b1;
        end else begin
          ras_count <= ras_count + 5'd1;
        end
      end else if (do_pop) begin
        sp           <= sp_dec;
        ras_count    <= ras_count - 5'd1;
        ret_mismatch <= (ras_top != reg_target);
      end
    end
  end
`else
  assign ras_top      = '0;
  assign ras_count    = 5'd0;
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
  assign ras_overflow = 1'b0;
  assign ret_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit -- self-checking bench for pc_ras_unit (default parameters).
// Table-driven next-PC vectors with a scoreboard queue of expected PC values,
// followed by hand-written reset and RAS sequences.
module tb_pc_ras_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [2:0]    pc_src;
  logic          zero;
  logic [25:0]   instr_index;
  logic [W-1:0]  reg_target;
  logic [W-1:0]  pc;
  logic [W-1:0]  npc;
  logic [W-1:0]  pc4;
  logic [W-1:0]  ras_top;
  logic [4:0]    ras_count;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_overflow;
  logic          ret_mismatch;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] model_pc = 32'h0000_3000;

  typedef struct packed {
    logic        en;
    logic [2:0]  src;
    logic        zero;
    logic [25:0] idx;
    logic [31:0] rt;
    logic [31:0] exp_npc;
  } vec_t;

  vec_t vecs [15];

  pc_ras_unit dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .pc_src       (pc_src),
    .zero         (zero),
    .instr_index  (instr_index),
    .reg_target   (reg_target),
    .pc           (pc),
    .npc          (npc),
    .pc4          (pc4),
    .ras_top      (ras_top),
    .ras_count    (ras_count),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow),
    .ret_mismatch (ret_mismatch)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs, and queue
  // the PC expected after the next edge.
  task automatic applyStimulus(input logic e, input logic [2:0] s, input logic z,
                               input logic [25:0] idx, input logic [31:0] rt,
                               input logic [31:0] exp_npc);
    logic [31:0] exp_pc4;
    en          = e;
    pc_src      = s;
    zero        = z;
    instr_index = idx;
    reg_target  = rt;
    exp_q.push_back(e ? exp_npc : model_pc);
    #1;
    exp_pc4 = model_pc + 32'd4;
    checkOutput("npc", npc, exp_npc);
    checkOutput("pc4", pc4, exp_pc4);
  endtask

  // Advance one edge and compare the registered PC against the scoreboard.
  task automatic stepClock();
    logic [31:0] exp_pc;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard: queue empty, pc %h", pc);
    end else begin
      checks--;
      exp_pc = exp_q.pop_front();
      checkOutput("pc", pc, exp_pc);
      model_pc = exp_pc;
    end
  endtask

  task automatic doReset(input logic e, input logic [2:0] s);
    reset       = 1'b0;
    en          = e;
    pc_src      = s;
    zero        = 1'b0;
    instr_index = 26'h0000C10;
    reg_target  = 32'h0000_1234;
    exp_q.push_back(32'h0000_3000);
    stepClock();
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    en          = 1'b0;
    pc_src      = 3'd0;
    zero        = 1'b0;
    instr_index = '0;
    reg_target  = '0;

    vecs[0]  = '{1'b1, 3'd1, 1'b1, 26'h000FFFF, 32'h0, 32'h0000_3000};
    vecs[1]  = '{1'b0, 3'd1, 1'b0, 26'h2A0FFFF, 32'h0, 32'h0000_3004};
    vecs[2]  = '{1'b0, 3'd2, 1'b0, 26'h0000002, 32'h0, 32'h0000_300C};
    vecs[3]  = '{1'b1, 3'd2, 1'b1, 26'h0000002, 32'h0, 32'h0000_3004};
    vecs[4]  = '{1'b1, 3'd0, 1'b0, 26'h0000000, 32'h0, 32'h0000_3008};
    vecs[5]  = '{1'b1, 3'd7, 1'b1, 26'h0000040, 32'h0, 32'h0000_300C};
    vecs[6]  = '{1'b1, 3'd0, 1'b0, 26'h0000000, 32'h0, 32'h0000_3010};
    vecs[7]  = '{1'b0, 3'd3, 1'b0, 26'h0000C10, 32'h0, 32'h0000_3040};
    vecs[8]  = '{1'b1, 3'd3, 1'b0, 26'h0000C10, 32'h0, 32'h0000_3040};
    vecs[9]  = '{1'b1, 3'd5, 1'b0, 26'h0000000, 32'h0000_5000, 32'h0000_5000};
    vecs[10] = '{1'b1, 3'd1, 1'b1, 26'h0008000, 32'h0, 32'hFFFE_5004};
    vecs[11] = '{1'b1, 3'd3, 1'b0, 26'h3FFFFFF, 32'h0, 32'hFFFF_FFFC};
    vecs[12] = '{1'b1, 3'd0, 1'b0, 26'h0000000, 32'h0, 32'h0000_0000};
    vecs[13] = '{1'b1, 3'd4, 1'b0, 26'h0000C00, 32'h0, 32'h0000_3000};
    vecs[14] = '{1'b1, 3'd6, 1'b0, 26'h0000000, 32'h0000_3004, 32'h0000_3004};

    $display("[TB] reset check");
    doReset(1'b1, 3'd3);
    checkOutput("reset_count", 32'(ras_count), 32'd0);
    checkOutput("reset_empty", 32'(ras_empty), 32'd1);
    checkOutput("reset_full", 32'(ras_full), 32'd0);
    checkOutput("reset_top", ras_top, 32'd0);
    checkOutput("reset_ovf", 32'(ras_overflow), 32'd0);
    checkOutput("reset_mism", 32'(ret_mismatch), 32'd0);

    $display("[TB] next-PC vector table");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].en, vecs[i].src, vecs[i].zero, vecs[i].idx,
                    vecs[i].rt, vecs[i].exp_npc);
      stepClock();
    end

`ifdef PC_RAS_UNIT_RAS_EN
    $display("[TB] call/return sequence");
    doReset(1'b1, 3'd4);
    applyStimulus(1'b1, 3'd4, 1'b0, 26'h0000C00, 32'h0, 32'h0000_3000);
    stepClock();
    checkOutput("call_top", ras_top, 32'h0000_3004);
    checkOutput("call_count", 32'(ras_count), 32'd1);
    applyStimulus(1'b1, 3'd6, 1'b0, 26'h0, 32'h0000_3004, 32'h0000_3004);
    stepClock();
    checkOutput("ret_count", 32'(ras_count), 32'd0);
    checkOutput("ret_match", 32'(ret_mismatch), 32'd0);
    applyStimulus(1'b1, 3'd3, 1'b0, 26'h0000C00, 32'h0, 32'h0000_3000);
    stepClock();
    applyStimulus(1'b1, 3'd4, 1'b0, 26'h0000C00, 32'h0, 32'h0000_3000);
    stepClock();
    applyStimulus(1'b1, 3'd6, 1'b0, 26'h0, 32'h0000_3008, 32'h0000_3008);
    stepClock();
    checkOutput("ret_mism_pulse", 32'(ret_mismatch), 32'd1);
    checkOutput("ret_mism_count", 32'(ras_count), 32'd0);
    applyStimulus(1'b1, 3'd3, 1'b0, 26'h0000C00, 32'h0, 32'h0000_3000);
    stepClock();
    checkOutput("ret_mism_clear", 32'(ret_mismatch), 32'd0);

    $display("[TB] overflow sequence");
    for (int i = 0; i < 5; i++) begin
      logic [31:0] tgt;
      tgt = (i < 4) ? 32'h0000_3010 + 32'(i) * 32'h10 : 32'h0000_3000;
      applyStimulus(1'b1, 3'd4, 1'b0, tgt[27:2], 32'h0, tgt);
      stepClock();
    end
    checkOutput("ovf_count", 32'(ras_count), 32'd4);
    checkOutput("ovf_flag", 32'(ras_overflow), 32'd1);
    checkOutput("ovf_full", 32'(ras_full), 32'd1);
    checkOutput("ovf_top", ras_top, 32'h0000_3044);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] rt;
      rt = 32'h0000_3044 - 32'(i) * 32'h10;
      applyStimulus(1'b1, 3'd6, 1'b0, 26'h0, rt, rt);
      stepClock();
      checkOutput("pop_mism", 32'(ret_mismatch), 32'd0);
    end
    checkOutput("pop_empty", 32'(ras_empty), 32'd1);
    applyStimulus(1'b1, 3'd6, 1'b0, 26'h0, 32'h0000_1234, 32'h0000_1234);
    stepClock();
    checkOutput("empty_ret_mism", 32'(ret_mismatch), 32'd0);
    checkOutput("empty_ret_count", 32'(ras_count), 32'd0);
    checkOutput("ovf_sticky", 32'(ras_overflow), 32'd1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 3'd3, 1'b0, 26'h0000C00, 32'h0, 32'h0000_3000);
    stepClock();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd4, 1'b0, 26'h0000C00, 32'h0, 32'h0000_3000);
      stepClock();
    end
    checkOutput("mid_count", 32'(ras_count), 32'd3);
    doReset(1'b1, 3'd4);
    checkOutput("mid_rst_count", 32'(ras_count), 32'd0);
    checkOutput("mid_rst_ovf", 32'(ras_overflow), 32'd0);
    checkOutput("mid_rst_top", ras_top, 32'd0);
`else
    $display("[TB] RAS disabled: tied outputs and reset mid-operation");
    checkOutput("tie_count", 32'(ras_count), 32'd0);
    checkOutput("tie_empty", 32'(ras_empty), 32'd1);
    checkOutput("tie_full", 32'(ras_full), 32'd0);
    checkOutput("tie_top", ras_top, 32'd0);
    checkOutput("tie_ovf", 32'(ras_overflow), 32'd0);
    checkOutput("tie_mism", 32'(ret_mismatch), 32'd0);
    applyStimulus(1'b1, 3'd3, 1'b0, 26'h0000C10, 32'h0, 32'h0000_3040);
    stepClock();
    doReset(1'b0, 3'd4);
    applyStimulus(1'b1, 3'd4, 1'b0, 26'h0000C10, 32'h0, 32'h0000_3040);
    stepClock();
    checkOutput("call_as_jump_count", 32'(ras_count), 32'd0);
    applyStimulus(1'b1, 3'd6, 1'b0, 26'h0, 32'h0000_3008, 32'h0000_3008);
    stepClock();
    checkOutput("ret_as_jreg_mism", 32'(ret_mismatch), 32'd0);
`endif

    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    checks++;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning PC/target width, legal range 28..64.
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_3000, meaning PC value loaded on reset (zero-extended or truncated to WIDTH).
REQ-003 SHALL provide parameter RAS_DEPTH, default 4, meaning return-address-stack entries, legal range 2..16.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock; one clock; reset is synchronous and active-low (port reset).
REQ-005 SHALL have ports: en  in  1  PC/RAS update enable (0 = stall); pc_src  in  3  next-PC mode; zero  in  1  ALU equality flag.
REQ-006 SHALL have ports: instr_index  in  26  jump index, bits [15:0] also branch offset; reg_target  in  WIDTH  GPR jump-register value.
REQ-007 SHALL have ports: pc  out  WIDTH  current PC (registered); npc  out  WIDTH  next PC (combinational); pc4  out  WIDTH  pc+4.
REQ-008 SHALL have ports: ras_top  out  WIDTH  top RAS entry; ras_count  out  5  valid entries; ras_empty, ras_full, ras_overflow, ret_mismatch  out  1 each.

Function
REQ-009 SHALL decode pc_src: 0 SEQ, 1 BEQ, 2 BNE, 3 JUMP, 4 CALL, 5 JREG, 6 RET, 7 reserved treated as SEQ.
REQ-010 SHALL compute npc: SEQ -> pc4; BEQ -> branch target if zero=1 else pc4; BNE -> branch target if zero=0 else pc4.
REQ-011 SHALL form branch target as pc4 + sign-extend(instr_index[15:0]) << 2, modulo 2^WIDTH (wrap, no flag).
REQ-012 SHALL form JUMP/CALL target as {pc[WIDTH-1:28], instr_index, 2'b00}.
REQ-013 SHALL set npc = reg_target for JREG and RET; RAS contents never override architectural target.
REQ-014 SHALL load pc <= npc on each rising edge with reset=1 and en=1; hold pc when en=0.
REQ-015 SHALL, on CALL with en=1, push pc4 onto the RAS; ras_count increments, saturating at RAS_DEPTH.
REQ-016 SHALL, on CALL with en=1 while ras_full, overwrite the oldest entry (circular), keep ras_count=RAS_DEPTH, set ras_overflow sticky.
REQ-017 SHALL, on RET with en=1 and ras_count>0, pop the top entry; ras_count decrements.
REQ-018 SHALL, on RET with en=1 and ras_empty, leave RAS unchanged and not signal mismatch.
REQ-019 SHALL register ret_mismatch=1 for exactly one cycle after a RET with en=1, RAS non-empty, and ras_top != reg_target; else 0.
REQ-020 SHALL not push, pop, or update ret_mismatch (driven 0) when en=0.
REQ-021 SHALL drive ras_top = 0 when ras_empty; ras_empty=(count==0), ras_full=(count==RAS_DEPTH), combinational from count.
REQ-022 SHALL keep pc4 = pc + 4 modulo 2^WIDTH at all times.

Reset
REQ-023 SHALL, on rising edge with reset=0, set pc=RESET_PC, ras_count=0, stack pointer=0, all RAS entries=0, ras_overflow=0, ret_mismatch=0, regardless of en/pc_src.
REQ-024 SHALL give reset priority over any CALL/RET in the same cycle; a push/pop in progress is discarded.

Configuration
REQ-025 SHALL compile the RAS only when macro PC_RAS_UNIT_RAS_EN is defined.
REQ-026 SHALL, without PC_RAS_UNIT_RAS_EN, treat CALL as JUMP and RET as JREG, tie ras_top=0, ras_count=0, ras_empty=1, ras_full=0, ras_overflow=0, ret_mismatch=0; npc/pc behaviour unchanged.

Verification
REQ-027 SHALL verify reset: reset=0 one edge, en=1, pc_src=3 -> pc=32'h0000_3000, ras_count=0, ras_empty=1.
REQ-028 SHALL verify branches: pc=32'h3000, pc_src=1, zero=1, offset=16'hFFFF -> npc=32'h3000; zero=0 -> npc=32'h3004; pc_src=2, zero=0, offset=16'h0002 -> npc=32'h300C.
REQ-029 SHALL verify jump/stall: pc=32'h3010, pc_src=3, instr_index=26'h0000C10, en=0 -> pc stays 32'h3010; en=1 -> pc=32'h0000_3040.
REQ-030 SHALL verify call/return: CALL at pc=32'h3000 -> ras_top=32'h3004, count=1; RET with reg_target=32'h3004 -> count=0, ret_mismatch=0 next cycle; repeat with reg_target=32'h3008 -> ret_mismatch=1 one cycle, npc=32'h3008.
REQ-031 SHALL verify overflow: 5 CALLs (RAS_DEPTH=4) from pcs 32'h3000,3010,3020,3030,3040 -> count=4, ras_overflow=1, ras_top=32'h3044; 4 RETs then RET on empty -> count=0, no mismatch.
REQ-032 SHALL verify reset mid-operation: count=3, reset=0 with pc_src=4 same edge -> count=0, ras_overflow=0, pc=RESET_PC.
